// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator with IF/ID pipeline register and RUN/HALT control.
// Optional build macro FETCH_CNT_EN adds a saturating count of valid fetches on port fetch_cnt.
//
// state | meaning
// RUN   | fetching; redirect > halt_req > stall > advance each cycle
// HALT  | pc frozen, IF/ID invalid; only resume (or reset) leaves
module if_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        flush,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc,
    output logic        ifhalt,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        misalign_err
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        misalign_q, misalign_d;
    logic        fetch_fire;

    // Next-state and datapath selection; the incrementer result is only taken on advance.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        misalign_d   = misalign_q;
        fetch_fire   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redirect) begin
                    pc_d         = {redirect_pc[31:2], 2'b00};
                    ifid_valid_d = 1'b0;
                    if (redirect_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                end else if (halt_req) begin
                    state_d      = HALT;
                    ifid_valid_d = 1'b0;
                end else if (stall) begin
                    if (flush) begin
                        ifid_valid_d = 1'b0;
                    end
                end else begin
                    ifid_pc_d    = pc_q;
                    ifid_valid_d = !flush;
                    pc_d         = pc_next_in;
                    fetch_fire   = !flush;
                end
            end
            HALT: begin
                ifid_valid_d = 1'b0;
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Pipeline state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'h0;
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            misalign_q   <= misalign_d;
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    // Saturating increment whenever IF/ID captures a real instruction.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (fetch_fire && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    // Fetch counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
`else
    logic unused_fetch_fire;
    assign unused_fetch_fire = fetch_fire;
`endif

    assign pc           = pc_q;
    assign ifhalt       = (state_q == HALT);
    assign ifid_pc      = ifid_pc_q;
    assign ifid_valid   = ifid_valid_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_if_pc_gen.sv
// Scoreboard bench for if_pc_gen: driver pushes model expectations, monitor pops and compares.
module tb_if_pc_gen;

    logic        clk;
    logic        rst;
    logic [31:0] pc_next_in;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        flush;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic        ifhalt;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        misalign_err;
`ifdef FETCH_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    if_pc_gen #(.RESET_PC(32'h0000_3000)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_next_in   (pc_next_in),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .flush        (flush),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc           (pc),
        .ifhalt       (ifhalt),
        .ifid_pc      (ifid_pc),
        .ifid_valid   (ifid_valid),
        .misalign_err (misalign_err)
`ifdef FETCH_CNT_EN
        ,
        .fetch_cnt    (fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        halted;
        logic [31:0] ifid_pc;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state, advanced once per issued cycle.
    logic [31:0] m_pc     = 32'h0;
    logic        m_halted = 1'b0;
    logic [31:0] m_ifid   = 32'h0;
    logic        m_valid  = 1'b0;
    logic        m_mis    = 1'b0;
    logic [31:0] m_cnt    = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural rule set for one clock edge.
    task automatic model_step(input logic r, rd, input logic [31:0] rpc,
                              input logic st, fl, hr, rs, input logic [31:0] nxt);
        if (r) begin
            m_pc = 32'h3000; m_halted = 1'b0; m_ifid = 32'h0;
            m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        end else if (m_halted) begin
            m_valid = 1'b0;
            if (rs) m_halted = 1'b0;
        end else if (rd) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            if (rpc[1:0] != 2'b00) m_mis = 1'b1;
        end else if (hr) begin
            m_halted = 1'b1;
            m_valid = 1'b0;
        end else if (st) begin
            if (fl) m_valid = 1'b0;
        end else begin
            m_ifid = m_pc;
            m_valid = !fl;
            m_pc = nxt;
            if (!fl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic drive_now(input logic r, rd, input logic [31:0] rpc,
                             input logic st, fl, hr, rs, input logic rnd_nxt);
        logic [31:0] nxt;
        exp_t e;
        nxt = rnd_nxt ? $urandom : (m_pc + 32'd4);
        rst = r; redirect = rd; redirect_pc = rpc; stall = st;
        flush = fl; halt_req = hr; resume = rs; pc_next_in = nxt;
        model_step(r, rd, rpc, st, fl, hr, rs, nxt);
        e.pc = m_pc; e.halted = m_halted; e.ifid_pc = m_ifid;
        e.valid = m_valid; e.mis = m_mis; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic r, rd, input logic [31:0] rpc,
                       input logic st, fl, hr, rs, input logic rnd_nxt);
        @(negedge clk);
        drive_now(r, rd, rpc, st, fl, hr, rs, rnd_nxt);
    endtask

    task automatic adv();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_ifhalt", {31'h0, ifhalt}, {31'h0, e.halted});
                chk("sb_ifid_pc", ifid_pc, e.ifid_pc);
                chk("sb_ifid_valid", {31'h0, ifid_valid}, {31'h0, e.valid});
                chk("sb_misalign", {31'h0, misalign_err}, {31'h0, e.mis});
`ifdef FETCH_CNT_EN
                chk("sb_fetch_cnt", fetch_cnt, e.cnt);
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        flush = 1'b0; halt_req = 1'b0; resume = 1'b0; pc_next_in = 32'h0;

        // Reset and three sequential advances.
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("rst_pc", pc, 32'h3000);
        chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("rst_ifhalt", {31'h0, ifhalt}, 32'h0);
        adv(); settle();
        chk("adv1_pc", pc, 32'h3004);
        chk("adv1_ifid", ifid_pc, 32'h3000);
        chk("adv1_valid", {31'h0, ifid_valid}, 32'h1);
        adv(); adv(); settle();
        chk("adv3_pc", pc, 32'h300C);
        chk("adv3_ifid", ifid_pc, 32'h3008);

        // Stall two cycles at 3008, flush in the second.
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        adv(); adv();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("stall1_pc", pc, 32'h3008);
        chk("stall1_ifid", ifid_pc, 32'h3004);
        chk("stall1_valid", {31'h0, ifid_valid}, 32'h1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        chk("stall2_pc", pc, 32'h3008);
        chk("stall2_valid", {31'h0, ifid_valid}, 32'h0);

        // Misaligned redirect beats stall and halt_req.
        cyc(1'b0, 1'b1, 32'h3102, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        settle();
        chk("redir_pc", pc, 32'h3100);
        chk("redir_valid", {31'h0, ifid_valid}, 32'h0);
        chk("redir_mis", {31'h0, misalign_err}, 32'h1);
        chk("redir_ifhalt", {31'h0, ifhalt}, 32'h0);
        adv(); settle();
        chk("redir_run_pc", pc, 32'h3104);

        // Halt at 3010, ignore redirect/stall/flush while halted, resume beats halt_req.
        cyc(1'b0, 1'b1, 32'h3010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        settle();
        chk("halt_ifhalt", {31'h0, ifhalt}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, $urandom, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            settle();
            chk("halt_hold_pc", pc, 32'h3010);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        chk("resume_ifhalt", {31'h0, ifhalt}, 32'h0);
        chk("resume_pc", pc, 32'h3010);
        adv(); settle();
        chk("resume_ifid", ifid_pc, 32'h3010);
        chk("resume_valid", {31'h0, ifid_valid}, 32'h1);

        // Reset while halted with misalign set.
        cyc(1'b0, 1'b1, 32'h3201, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h3333, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        settle();
        chk("rsth_pc", pc, 32'h3000);
        chk("rsth_ifhalt", {31'h0, ifhalt}, 32'h0);
        chk("rsth_mis", {31'h0, misalign_err}, 32'h0);
`ifdef FETCH_CNT_EN
        chk("rsth_cnt", fetch_cnt, 32'h0);
`endif

        // Randomized traffic, checked by the scoreboard only.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(99) < 2, $urandom_range(99) < 8,
                32'h3000 + 32'($urandom_range(1023)),
                $urandom_range(99) < 20, $urandom_range(99) < 15,
                $urandom_range(99) < 5, $urandom_range(99) < 30,
                $urandom_range(99) < 20);
        end

`ifdef FETCH_CNT_EN
        // Ten advances, one flushed, then saturation from a preloaded value.
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, (i == 4), 1'b0, 1'b0, 1'b0);
        end
        settle();
        chk("cnt_nine", fetch_cnt, 32'd9);
        @(negedge clk);
        dut.fetch_cnt_q = 32'hFFFF_FFFD;
        m_cnt = 32'hFFFF_FFFD;
        drive_now(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) adv();
        settle();
        chk("cnt_sat", fetch_cnt, 32'hFFFF_FFFF);
`endif

        repeat (3) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_pc_gen.md
IF_PC_GEN -- requirements
Module: if_pc_gen

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, the PC value loaded on reset.
REQ-002 The block SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port pc_next_in  in  32  sequential next PC returned by the PC incrementer.
REQ-005 The block SHALL have port redirect  in  1  taken branch or jump from EX.
REQ-006 The block SHALL have port redirect_pc  in  32  redirect target.
REQ-007 The block SHALL have port stall  in  1  hazard-unit hold of PC and IF/ID.
REQ-008 The block SHALL have port flush  in  1  invalidate IF/ID.
REQ-009 The block SHALL have port halt_req  in  1  ebreak/halt detected; enter HALT.
REQ-010 The block SHALL have port resume  in  1  leave HALT.
REQ-011 The block SHALL have port pc  out  32  current fetch PC, driving the incrementer input.
REQ-012 The block SHALL have port ifhalt  out  1  halt indication to the incrementer, equal to (state==HALT).
REQ-013 The block SHALL have port ifid_pc  out  32  IF/ID register PC.
REQ-014 The block SHALL have port ifid_valid  out  1  IF/ID register holds a real instruction.
REQ-015 The block SHALL have port misalign_err  out  1  sticky flag, set when a redirect target is not word-aligned.
REQ-016 The block SHALL have port fetch_cnt  out  32  valid-fetch counter, present only under FETCH_CNT_EN.

Function
REQ-017 The block SHALL implement a two-state FSM, RUN and HALT.
REQ-018 In RUN, the block SHALL apply per-cycle priority redirect > halt_req > stall > advance.
REQ-019 On a RUN redirect, the block SHALL load pc <= {redirect_pc[31:2],2'b00} and ifid_valid <= 0, and SHALL ignore stall and halt_req in that cycle.
REQ-020 Whenever redirect_pc[1:0]!=0 on an accepted redirect, the block SHALL set misalign_err and hold it until reset.
REQ-021 On halt_req in RUN without redirect, the block SHALL go to HALT, hold pc and set ifid_valid <= 0; ifhalt SHALL be 1 from the next cycle.
REQ-022 On stall in RUN, the block SHALL hold pc, ifid_pc and ifid_valid; flush, if also asserted, SHALL still clear ifid_valid.
REQ-023 On advance in RUN, the block SHALL load ifid_pc <= pc, ifid_valid <= !flush and pc <= pc_next_in, giving a one-cycle PC-to-IF/ID latency.
REQ-024 In HALT, the block SHALL hold pc, keep ifid_valid at 0, and ignore redirect, stall and flush.
REQ-025 On resume in HALT, the block SHALL return to RUN next cycle with pc unchanged, the first fetch advancing in the following cycle.
REQ-026 With halt_req and resume both asserted in HALT, resume SHALL win.
REQ-027 pc_next_in SHALL be sampled only on advance cycles; the block SHALL perform no addition itself.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL set pc=RESET_PC, state=RUN, ifid_pc=0, ifid_valid=0, misalign_err=0 and fetch_cnt=0, overriding all other inputs including mid-halt and mid-stall.
REQ-029 All outputs SHALL be stable reset values in the cycle after the reset edge; the first advance SHALL occur on the first edge with rst=0.

Configuration
REQ-030 With macro FETCH_CNT_EN defined, the block SHALL include a 32-bit fetch_cnt that increments on each edge where ifid_valid is loaded 1 and saturates at 32'hFFFF_FFFF.
REQ-031 Without FETCH_CNT_EN, the fetch_cnt port and its register SHALL be absent, with all other behaviour identical.

Verification
REQ-032 The bench SHALL check: reset, then 3 advances with incrementer pc+4 -> pc 3000,3004,3008,300C; ifid_pc lags pc by 1 cycle; ifid_valid=1 from 2nd edge.
REQ-033 The bench SHALL check: stall 2 cycles at pc=3008 -> pc and ifid_pc hold; with flush in 2nd stall cycle -> ifid_valid=0 while pc holds.
REQ-034 The bench SHALL check: redirect=1, redirect_pc=3102 with stall=1 and halt_req=1 -> pc=3100, ifid_valid=0, misalign_err=1, state stays RUN.
REQ-035 The bench SHALL check: halt_req at pc=3010 -> ifhalt=1, pc holds 3010 for 5 cycles despite redirect; resume -> ifhalt=0, next advance loads ifid_pc=3010.
REQ-036 The bench SHALL check: rst asserted during HALT with misalign_err=1 -> pc=3000, ifhalt=0, misalign_err=0, fetch_cnt=0.
REQ-037 The bench SHALL check, under FETCH_CNT_EN: 10 valid fetches with one flush -> fetch_cnt=9; preload near all-ones -> fetch_cnt saturates at FFFF_FFFF.
